// File: rtl/tree_node_sequencer_pkg.sv
// Shared state encoding and sizing helper for the tree node sequencer.
package tree_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_FINISH
    } seq_state_e;

    // Width of a child index; a single child still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tree_node_sequencer_if.sv
// Control bundle between the sequencer and whatever starts it and supervises its children.
interface tree_node_sequencer_if #(
    parameter int NUM_CHILDREN = 5,
    parameter int TIMEOUT_W    = 8
);
    import tree_seq_pkg::*;

    localparam int IDX_W = idx_width(NUM_CHILDREN);

    logic                    start_i;
    logic [TIMEOUT_W-1:0]    timeout_i;
    logic [NUM_CHILDREN-1:0] child_start_o;
    logic [NUM_CHILDREN-1:0] child_done_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic [NUM_CHILDREN-1:0] done_mask_o;
    logic [IDX_W-1:0]        err_idx_o;

    modport master (
        output start_i, timeout_i, child_done_i,
        input  child_start_o, busy_o, done_o, err_o, done_mask_o, err_idx_o
    );

    modport slave (
        input  start_i, timeout_i, child_done_i,
        output child_start_o, busy_o, done_o, err_o, done_mask_o, err_idx_o
    );

endinterface

// File: rtl/tree_node_sequencer_timer.sv
// Saturating up-counter measuring a WAIT period against the limit captured at start.
module tree_seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the timeout entirely.
    assign expired_o = (limit_i != '0) && (cnt_q == limit_i);

endmodule

// File: rtl/tree_node_sequencer.sv
// Launches a set of child blocks (one by one or all at once) and reports completion or timeout.
// state  | meaning
// IDLE   | waiting for start_i
// LAUNCH | one-cycle child_start_o pulse, timer cleared
// WAIT   | collecting child_done_i, timing the wait
// FINISH | one-cycle done_o pulse
module tree_node_sequencer
    import tree_seq_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int TIMEOUT_W    = 8,
    parameter int PARALLEL     = 0
) (
    input logic                 clk,
    input logic                 rst,
    tree_node_sequencer_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_CHILDREN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILDREN - 1);

    seq_state_e              state_q, state_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic [IDX_W-1:0]        err_idx_q, err_idx_d;
    logic [TIMEOUT_W-1:0]    limit_q, limit_d;
    logic [NUM_CHILDREN-1:0] mask_q, mask_d;
    logic                    err_q, err_d;
    logic [NUM_CHILDREN-1:0] cur_bit, par_mask, child_start;
    logic [IDX_W-1:0]        lowest_free;
    logic                    done_pulse, tmr_clear, tmr_en, tmr_expired;

    assign cur_bit  = NUM_CHILDREN'(1) << k_q;
    assign par_mask = mask_q | bus.child_done_i;

    always_comb begin
        lowest_free = '0;
        for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
            if (!par_mask[i]) lowest_free = IDX_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        limit_d     = limit_q;
        mask_d      = mask_q;
        err_d       = err_q;
        err_idx_d   = err_idx_q;
        child_start = '0;
        done_pulse  = 1'b0;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    mask_d    = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    limit_d   = bus.timeout_i;
                    k_d       = '0;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                child_start = (PARALLEL != 0) ? '1 : cur_bit;
                tmr_clear   = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is evaluated before expiry so a done on the expiry cycle wins.
                if (PARALLEL != 0) begin
                    mask_d = par_mask;
                    if (&par_mask) begin
                        state_d = ST_FINISH;
                    end else if (tmr_expired) begin
                        err_d     = 1'b1;
                        err_idx_d = lowest_free;
                        state_d   = ST_FINISH;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end else if (|(bus.child_done_i & cur_bit)) begin
                    mask_d = mask_q | cur_bit;
                    if (k_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_LAUNCH;
                    end
                end else if (tmr_expired) begin
                    err_d     = 1'b1;
                    err_idx_d = k_q;
                    state_d   = ST_FINISH;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_FINISH: begin
                done_pulse = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            limit_q   <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            limit_q   <= limit_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    tree_seq_timer #(.WIDTH(TIMEOUT_W)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_en),
        .limit_i   (limit_q),
        .expired_o (tmr_expired)
    );

    assign bus.child_start_o = child_start;
    assign bus.busy_o        = (state_q != ST_IDLE);
    assign bus.done_o        = done_pulse;
    assign bus.err_o         = err_q;
    assign bus.done_mask_o   = mask_q;
    assign bus.err_idx_o     = err_idx_q;

endmodule
